// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Types and constants shared by the parametrised SPI master.
//   state_e  : transfer FSM states (IDLE/LEAD/XFER/TRAIL)
//   MODE0..3 : SPI modes encoded as {CPOL, CPHA}
//   cs_width : width of a slave-select index for a given chip-select count
// ----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } state_e;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // A single slave still needs a one-bit select port.
    function automatic int cs_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_master_param_clk_gen.sv
// ----------------------------------------------------------------------------
// spi_clk_gen
// Half-period timebase for the SPI master. Counts CLK_DIV system clocks while
// enabled and raises tick_o for one cycle at the end of each half-period.
// The count is held at zero while disabled, so every transfer starts with a
// full half-period.
//   clk, reset : system clock, synchronous active-high reset
//   en_i       : count enable (high outside IDLE)
//   tick_o     : one-cycle pulse every CLK_DIV enabled cycles
// ----------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || !en_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_param.sv
// ----------------------------------------------------------------------------
// spi_master_param
// Parametrised full-duplex SPI master (all four CPOL/CPHA modes).
// Optional feature macro: SPI_LSB_FIRST_EN adds the lsb_first input, which
// selects LSB-first shifting per transfer; without it transfers are MSB-first.
//   clk, reset      : system clock, synchronous active-high reset
//   start           : one-cycle request, honoured only in IDLE
//   polarity, phase : CPOL / CPHA, captured at start
//   cs_sel          : slave index, captured at start (out of range = no slave)
//   data_wr         : transmit word, captured at start
//   data_rd         : received word, updated with done
//   busy, done      : transfer in progress / one-cycle completion pulse
//   spi_clk, cs     : SCLK and active-low chip selects
//   mosi, miso      : serial data out / in
// ----------------------------------------------------------------------------
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 1,
    parameter int CS_W    = cs_width(NUM_CS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              polarity,
    input  logic              phase,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] data_wr,
    output logic [DATA_W-1:0] data_rd,
    output logic              busy,
    output logic              done,
    output logic              spi_clk,
    output logic [NUM_CS-1:0] cs,
    output logic              mosi,
    input  logic              miso
`ifdef SPI_LSB_FIRST_EN
    ,
    input  logic              lsb_first
`endif
);

    localparam int CNT_W = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  edge_cnt_q;
    logic              cpha_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] data_rd_q;
    logic [NUM_CS-1:0] cs_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              busy_q;
    logic              done_q;
    logic              lsb_in;
    logic              lsb_q;
    logic              tick;

    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // Out-of-range selects match nothing, leaving every chip select high.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) v[i] = 1'b0;
        end
        return v;
    endfunction

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
    always_ff @(posedge clk) begin
        if (reset) begin
            lsb_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            lsb_q <= lsb_first;
        end
    end
`else
    assign lsb_in = 1'b0;
    assign lsb_q  = 1'b0;
`endif

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_q != IDLE),
        .tick_o (tick)
    );

    // Even edge indices are leading edges (away from CPOL). CPHA=0 samples on
    // leading and shifts on trailing (the final trailing edge has nothing left
    // to shift); CPHA=1 shifts on leading and samples on trailing.
    logic leading, last_edge, do_sample, do_shift;
    logic [DATA_W-1:0] rx_next;

    assign leading   = ~edge_cnt_q[0];
    assign last_edge = (edge_cnt_q == LAST_EDGE);
    assign do_sample = cpha_q ? ~leading : leading;
    assign do_shift  = cpha_q ? leading : (~leading && !last_edge);
    // LSB-first words enter at the top and move down so bit 0 ends up first.
    assign rx_next   = lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};

    // NOTE: every register here uses <= so all updates in a cycle see the
    // pre-edge values; mixing in = would make the order of statements matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            cpha_q     <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            data_rd_q  <= '0;
            cs_q       <= '1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= polarity;
                    if (start) begin
                        state_q    <= LEAD;
                        busy_q     <= 1'b1;
                        cpha_q     <= phase;
                        cs_q       <= cs_decode(cs_sel);
                        edge_cnt_q <= '0;
                        rx_q       <= '0;
                        if (phase) begin
                            tx_q   <= data_wr;
                            mosi_q <= 1'b0;
                        end else begin
                            // CPHA=0 slaves sample on the first edge, so the
                            // first bit must already be on the line.
                            mosi_q <= head_bit(data_wr, lsb_in);
                            tx_q   <= shift_out(data_wr, lsb_in);
                        end
                    end
                end
                LEAD, XFER: begin
                    if (tick) begin
                        sclk_q <= ~sclk_q;
                        if (do_sample) rx_q <= rx_next;
                        if (do_shift) begin
                            mosi_q <= head_bit(tx_q, lsb_q);
                            tx_q   <= shift_out(tx_q, lsb_q);
                        end
                        if (last_edge) begin
                            state_q <= TRAIL;
                        end else begin
                            state_q    <= XFER;
                            edge_cnt_q <= edge_cnt_q + CNT_W'(1);
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        cs_q      <= '1;
                        data_rd_q <= rx_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_rd = data_rd_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign spi_clk = sclk_q;
    assign cs      = cs_q;
    assign mosi    = mosi_q;

endmodule
